fetch_queue: RTL

- Instruction fetch queue between fetch_cycle and decode_cycle, replacing the single IF/ID register.
- Buffers up to DEPTH fetched {Instr, PC, PCPlus4} tuples so fetch can run ahead while decode stalls.
- Discards all buffered instructions on a taken branch/jump resolved in execute (PCSrcE).
- First-word-fall-through: the head entry drives the decode inputs directly from storage.

---
 rtl/fetch_queue_pkg.sv | 7 +
 rtl/fetch_queue.sv | 80 ++++++++
 2 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared RISC-V pipeline definitions used by the fetch queue and decode flush logic.
package fetch_queue_pkg;

  localparam int unsigned RV_XLEN   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: a first-word-fall-through FIFO
// of {instr, pc, pc+4} tuples, emptied by a taken control transfer in execute.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = RV_XLEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ValidF,
  input  logic [XLEN-1:0]              InstrF,
  input  logic [XLEN-1:0]              PCF,
  input  logic [XLEN-1:0]              PCPlus4F,
  output logic                         ReadyF,
  output logic                         ValidD,
  output logic [XLEN-1:0]              InstrD,
  output logic [XLEN-1:0]              PCD,
  output logic [XLEN-1:0]              PCPlus4D,
  input  logic                         StallD,
  input  logic                         FlushE,
  output logic [$clog2(DEPTH+1)-1:0]   CountQ
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  // Ready is based on registered occupancy only; a pop does not free a slot for
  // a push in the same cycle.
  assign ReadyF = (count != CW'(DEPTH));
  assign ValidD = (count != '0);
  assign push   = ValidF && ReadyF && !FlushE;
  assign pop    = ValidD && !StallD && !FlushE;
  assign CountQ = count;

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[tail] <= '{instr: InstrF, pc: PCF, pc_plus4: PCPlus4F};
    end
  end

  // An empty queue presents a NOP bubble rather than stale storage.
  always_comb begin
    InstrD   = XLEN'(NOP_INSTR);
    PCD      = '0;
    PCPlus4D = '0;
    if (ValidD) begin
      InstrD   = mem[head].instr;
      PCD      = mem[head].pc;
      PCPlus4D = mem[head].pc_plus4;
    end
  end

endmodule
